// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the bit-serial adder controller.
//  STATE_W / ST_*   FSM state width and state encodings
//  DEF_WIDTH        default operand width
//  maj3()           carry-out of a full adder (majority of three)
package serial_add_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned DEF_WIDTH = 8;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'b00;
    localparam logic [STATE_W-1:0] ST_SHIFT = 2'b01;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'b10;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a parallel requester and the serial adder.
//  start, a, b, cin      requester -> adder (sampled on accept)
//  busy, done            adder status (done is a one-cycle pulse)
//  sum, cout, ovf        result registers, valid when done pulses
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl_bit_adder.sv
// 1-bit full adder with a registered carry, stepped one bit per enabled clock.
//  clk, rst     clock, async active-high reset
//  clr          load carry with cin_load (start of an operation)
//  en           advance: carry <= majority(a, b, carry)
//  a, b         current operand bits
//  s            sum bit for the current a/b/carry (combinational)
//  c            carry state (carry into the current bit)
module serial_bit_adder
    import serial_add_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic a,
    input  logic b,
    input  logic cin_load,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ c;

    // Carry state: load on clear, otherwise ripple forward one bit per enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c <= 1'b0;
        end else if (clr) begin
            c <= cin_load;
        end else if (en) begin
            c <= maj3(a, b, c);
        end
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer for a bit-serial add: accepts A/B/cin, shifts WIDTH bit pairs
// LSB-first through serial_bit_adder, then presents sum/cout/ovf with a done pulse.
//  clk, rst     clock, async active-high reset
//  bus (slave)  start/a/b/cin in; busy/done/sum/cout/ovf out
// busy and done are decoded straight from the state register.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   s_sr;
    logic [WIDTH-1:0]   sum_q;
    logic [CNT_W-1:0]   cnt;
    logic               cout_q;
    logic               ovf_q;
    logic               adder_clr;
    logic               adder_en;
    logic               bit_s;
    logic               carry;
    logic               last_bit;
    logic               carry_out;

    assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
    assign carry_out = maj3(a_sr[0], b_sr[0], carry);

    serial_bit_adder u_bit_adder (
        .clk      (clk),
        .rst      (rst),
        .clr      (adder_clr),
        .en       (adder_en),
        .a        (a_sr[0]),
        .b        (b_sr[0]),
        .cin_load (bus.cin),
        .s        (bit_s),
        .c        (carry)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and adder control
    always_comb begin
        state_nxt = state;
        adder_clr = 1'b0;
        adder_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    adder_clr = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                adder_en = 1'b1;
                if (last_bit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand/sum shift registers, bit counter and result registers.
    // On the last bit the carry register still holds the carry into the MSB,
    // so ovf is that carry XOR the carry leaving the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adder_clr) begin
            a_sr <= bus.a;
            b_sr <= bus.b;
            cnt  <= '0;
        end else if (adder_en) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            s_sr <= {bit_s, s_sr[WIDTH-1:1]};
            cnt  <= cnt + CNT_W'(1);
            if (last_bit) begin
                sum_q  <= {bit_s, s_sr[WIDTH-1:1]};
                cout_q <= carry_out;
                ovf_q  <= carry ^ carry_out;
            end
        end
    end

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = (state == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   cyc;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Steps until done is seen (bounded); returns steps taken and busy samples seen
    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = 0;
        while (n < 40) begin
            if (bus.busy) bc++;
            if (bus.done) break;
            step();
            n++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
    endtask

    task automatic count_done(input int cycles, output int k);
        k = 0;
        repeat (cycles) begin
            step();
            if (bus.done) k++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic [7:0] es, input logic ec, input logic eo);
        int n;
        int bc;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = ci;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(n, bc);
        check({tag, "_latency"}, 32'(n + 1), 32'(WIDTH + 1));
        check({tag, "_busy_cycles"}, 32'(bc), 32'(WIDTH + 1));
        check({tag, "_sum"}, 32'(bus.sum), 32'(es));
        check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        step();
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    logic [7:0] op_a [3];
    logic [7:0] op_b [3];
    logic       op_c [3];
    logic [7:0] ex_s [3];
    logic       ex_c [3];
    logic       ex_o [3];

    initial begin
        int n;
        int bc;
        int k;
        int last_done;
        tests = 0;
        fails = 0;
        cyc   = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        // Reset state
        step();
        step();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout_ovf", {30'd0, bus.cout, bus.ovf}, 32'd0);
        rst = 1'b0;
        step();
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Basic adds
        run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_7f_00_c", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

        // Start and operand changes during SHIFT are ignored
        bus.a     = 8'h5A;
        bus.b     = 8'h3C;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        bus.cin   = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(n, bc);
        check("busy_start_sum", 32'(bus.sum), 32'h96);
        check("busy_start_ovf", 32'(bus.ovf), 32'd1);
        count_done(15, k);
        check("busy_start_single_done", 32'(k), 32'd0);

        // Reset in the 4th SHIFT cycle abandons the op and clears results
        bus.a     = 8'hFF;
        bus.b     = 8'h01;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_sum", 32'(bus.sum), 32'd0);
        check("mid_rst_cout_ovf", {30'd0, bus.cout, bus.ovf}, 32'd0);
        step();
        rst = 1'b0;
        count_done(15, k);
        check("mid_rst_no_done", 32'(k), 32'd0);
        run_op("add_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        // Back-to-back with start held high; next operands applied while busy
        op_a[0] = 8'h01; op_b[0] = 8'h02; op_c[0] = 1'b0; ex_s[0] = 8'h03; ex_c[0] = 1'b0; ex_o[0] = 1'b0;
        op_a[1] = 8'h80; op_b[1] = 8'h80; op_c[1] = 1'b0; ex_s[1] = 8'h00; ex_c[1] = 1'b1; ex_o[1] = 1'b1;
        op_a[2] = 8'h40; op_b[2] = 8'h40; op_c[2] = 1'b1; ex_s[2] = 8'h81; ex_c[2] = 1'b0; ex_o[2] = 1'b1;
        bus.a     = op_a[0];
        bus.b     = op_b[0];
        bus.cin   = op_c[0];
        bus.start = 1'b1;
        last_done = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            step();
            if (i < 2) begin
                bus.a   = op_a[i+1];
                bus.b   = op_b[i+1];
                bus.cin = op_c[i+1];
            end else begin
                bus.start = 1'b0;
                bus.a     = 8'hAA;
                bus.b     = 8'h55;
            end
            wait_done(n, bc);
            check($sformatf("b2b%0d_sum", i), 32'(bus.sum), 32'(ex_s[i]));
            check($sformatf("b2b%0d_cout_ovf", i), {30'd0, bus.cout, bus.ovf},
                  {30'd0, ex_c[i], ex_o[i]});
            if (i > 0) check($sformatf("b2b%0d_period", i), 32'(cyc - last_done), 32'd10);
            last_done = cyc;
        end
        count_done(15, k);
        check("b2b_stop", 32'(k), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
